// File: rtl/car_link_pkg.sv
// Shared byte map for the car command link: mode, steer, drive and function codes,
// plus the composition rule used by the remote so the car-side decoder sees one definition.
package car_link_pkg;

    typedef enum logic [1:0] {
        MODE_DRIVE = 2'b00,
        MODE_SPEED = 2'b01,
        MODE_FUNC  = 2'b10,
        MODE_FREE  = 2'b11
    } mode_e;

    localparam logic [1:0] STEER_STRAIGHT = 2'b00;
    localparam logic [1:0] STEER_RIGHT    = 2'b01;
    localparam logic [1:0] STEER_LEFT     = 2'b10;

    localparam logic [1:0] DRIVE_STOP = 2'b00;
    localparam logic [1:0] DRIVE_FWD  = 2'b01;
    localparam logic [1:0] DRIVE_BACK = 2'b10;

    localparam logic [1:0] FUNC_TRACK = 2'b00;
    localparam logic [1:0] FUNC_WALL  = 2'b01;
    localparam logic [1:0] FUNC_PARK  = 2'b10;
    localparam logic [1:0] FUNC_FREE  = 2'b11;

    // Conflicting requests (both directions at once) collapse to the neutral code.
    function automatic logic [7:0] compose_byte(
        input mode_e      mode,
        input logic       fwd,
        input logic       back,
        input logic       left,
        input logic       right,
        input logic       avoid,
        input logic [5:0] speed_set,
        input logic [1:0] func_sel
    );
        logic [5:0] payload;
        logic [1:0] steer;
        logic [1:0] drive;
        payload = '0;
        steer   = STEER_STRAIGHT;
        drive   = DRIVE_STOP;
        if (left && !right)      steer = STEER_LEFT;
        else if (right && !left) steer = STEER_RIGHT;
        if (fwd && !back)        drive = DRIVE_FWD;
        else if (back && !fwd)   drive = DRIVE_BACK;
        case (mode)
            MODE_DRIVE: payload = {1'b0, avoid, steer, drive};
            MODE_SPEED: payload = speed_set;
            MODE_FUNC:  payload = {4'b0000, func_sel};
            default:    payload = '0;
        endcase
        return {mode, payload};
    endfunction

endpackage

// File: rtl/remote_cmd_tx_if.sv
// Operator controls into the remote transmitter and its UART/status outputs.
// master drives controls and observes status; slave is the transmitter side.
interface remote_cmd_tx_if;
    logic [1:0] mode_sel;
    logic       fwd;
    logic       back;
    logic       left;
    logic       right;
    logic       avoid;
    logic [5:0] speed_set;
    logic [1:0] func_sel;
    logic       tx;
    logic       busy;
    logic [7:0] last_frame;
    logic [7:0] frame_cnt;

    modport master (
        output mode_sel, fwd, back, left, right, avoid, speed_set, func_sel,
        input  tx, busy, last_frame, frame_cnt
    );

    modport slave (
        input  mode_sel, fwd, back, left, right, avoid, speed_set, func_sel,
        output tx, busy, last_frame, frame_cnt
    );
endinterface

// File: rtl/remote_cmd_tx_uart_tx_byte.sv
// 8N1 UART byte transmitter: start pulse in IDLE launches a frame on the next cycle.
// Frame lasts 10*CLKS_PER_BIT cycles; start is ignored while busy (no backpressure path).
module uart_tx_byte
#(
    parameter int CLKS_PER_BIT = 5208
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

    state_e        state;
    state_e        state_nxt;
    logic [TW-1:0] timer;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          cell_end;

    assign cell_end = (timer == TW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            timer   <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE) begin
                timer   <= '0;
                bit_idx <= '0;
                if (start) shreg <= data;
            end else if (cell_end) begin
                timer <= '0;
                if (state == S_DATA) begin
                    shreg   <= shreg >> 1;
                    bit_idx <= bit_idx + 3'd1;
                end
            end else begin
                timer <= timer + TW'(1);
            end
        end
    end

    // Line level is a pure decode of registered state, so reset forces tx high in one cycle.
    always_comb begin
        state_nxt = state;
        tx        = 1'b1;
        busy      = 1'b1;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = S_START;
            end
            S_START: begin
                tx = 1'b0;
                if (cell_end) state_nxt = S_DATA;
            end
            S_DATA: begin
                tx = shreg[0];
                if (cell_end && bit_idx == 3'd7) state_nxt = S_STOP;
            end
            S_STOP: begin
                if (cell_end) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: rtl/remote_cmd_tx.sv
// Remote command transmitter: composes the command byte, sends on change and on keep-alive expiry.
// Latency: compose 1 cycle, launch the cycle after pending is seen in IDLE; changes mid-frame coalesce.
module remote_cmd_tx
    import car_link_pkg::*;
#(
    parameter int CLK_HZ         = 50_000_000,
    parameter int BAUD           = 9600,
    parameter int CLKS_PER_BIT   = CLK_HZ / BAUD,
    parameter int REFRESH_CYCLES = 2_500_000
)
(
    input  logic          clk_50M,
    input  logic          rst,
    remote_cmd_tx_if.slave bus
);

    localparam int RW = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;

    logic [7:0]    composed;
    logic [7:0]    last_frame;
    logic [7:0]    frame_cnt;
    logic          pending;
    logic          busy;
    logic          launch;
    logic          refresh_run;
    logic          refresh_hit;
    logic [RW-1:0] refresh_cnt;

    // Free-running composition register, also loading during reset so the first frame is current.
    always_ff @(posedge clk_50M) begin
        composed <= compose_byte(mode_e'(bus.mode_sel), bus.fwd, bus.back, bus.left,
                                 bus.right, bus.avoid, bus.speed_set, bus.func_sel);
    end

    assign launch      = !busy && pending;
    assign refresh_run = !busy && !pending;
    // Flag on the step into REFRESH_CYCLES-1 so the resend period is frame + REFRESH_CYCLES.
    assign refresh_hit = refresh_run && (refresh_cnt == RW'(REFRESH_CYCLES - 2));

    always_ff @(posedge clk_50M) begin
        if (rst) begin
            pending     <= 1'b1;
            refresh_cnt <= '0;
            last_frame  <= '0;
            frame_cnt   <= '0;
        end else if (launch) begin
            pending     <= 1'b0;
            refresh_cnt <= '0;
            last_frame  <= composed;
            frame_cnt   <= frame_cnt + 8'd1;
        end else begin
            if (composed != last_frame || refresh_hit) pending <= 1'b1;
            if (refresh_run) refresh_cnt <= refresh_cnt + RW'(1);
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart (
        .clk   (clk_50M),
        .rst   (rst),
        .start (launch),
        .data  (composed),
        .tx    (bus.tx),
        .busy  (busy)
    );

    assign bus.busy       = busy;
    assign bus.last_frame = last_frame;
    assign bus.frame_cnt  = frame_cnt;

endmodule

// File: tb/tb_remote_cmd_tx.sv
// Scoreboard bench for remote_cmd_tx with shortened bit cell and keep-alive period.
module tb_remote_cmd_tx;

    localparam int C     = 16;
    localparam int R     = 600;
    localparam int FRAME = 10 * C;

    logic clk_50M = 1'b0;
    logic rst     = 1'b1;
    always #5 clk_50M = ~clk_50M;

    remote_cmd_tx_if bus();

    remote_cmd_tx #(
        .CLKS_PER_BIT  (C),
        .REFRESH_CYCLES(R)
    ) dut (
        .clk_50M(clk_50M),
        .rst    (rst),
        .bus    (bus)
    );

    int         vectors     = 0;
    int         miscompares = 0;
    int         cyc         = 0;
    int         frames_done = 0;
    logic [7:0] exp_q[$];
    int         launch_cyc[$];
    logic [7:0] model_last;

    always @(posedge clk_50M) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference byte map written from the operator-control rules.
    function automatic logic [7:0] model(input logic [1:0] m, input logic f, input logic b,
                                         input logic l, input logic r, input logic a,
                                         input logic [5:0] sp, input logic [1:0] fn);
        int v;
        v = int'(m) * 64;
        case (m)
            2'd0: begin
                v += int'(a) * 16;
                if (l && !r) v += 8; else if (r && !l) v += 4;
                if (f && !b) v += 1; else if (b && !f) v += 2;
            end
            2'd1: v += int'(sp);
            2'd2: v += int'(fn);
            default: ;
        endcase
        return v[7:0];
    endfunction

    function automatic logic [7:0] cur_model();
        return model(bus.mode_sel, bus.fwd, bus.back, bus.left, bus.right, bus.avoid,
                     bus.speed_set, bus.func_sel);
    endfunction

    task automatic set_inputs(input logic [1:0] m, input logic f, input logic b, input logic l,
                              input logic r, input logic a, input logic [5:0] sp,
                              input logic [1:0] fn);
        @(posedge clk_50M); #1;
        bus.mode_sel = m; bus.fwd = f; bus.back = b; bus.left = l; bus.right = r;
        bus.avoid = a; bus.speed_set = sp; bus.func_sel = fn;
    endtask

    task automatic expect_current(output bit pushed);
        logic [7:0] e;
        e = cur_model();
        pushed = (e != model_last);
        if (pushed) begin
            exp_q.push_back(e);
            model_last = e;
        end
    endtask

    task automatic wait_frames(input int n, input string name);
        int target;
        target = frames_done + n;
        for (int i = 0; i < n * (FRAME + R + 60) && frames_done < target; i++) @(negedge clk_50M);
        check({"frames_", name}, frames_done, target);
    endtask

    task automatic step(input logic [1:0] m, input logic f, input logic b, input logic l,
                        input logic r, input logic a, input logic [5:0] sp,
                        input logic [1:0] fn, input string name);
        bit pushed;
        set_inputs(m, f, b, l, r, a, sp, fn);
        expect_current(pushed);
        if (pushed) wait_frames(1, name);
        else repeat (4) @(posedge clk_50M);
    endtask

    task automatic wait_busy(input string name);
        for (int i = 0; i < 20 && !bus.busy; i++) @(negedge clk_50M);
        check({"busy_rise_", name}, bus.busy, 1);
    endtask

    // Monitor: decodes every frame on tx, checking each bit cell's first, middle and last cycle.
    initial begin : monitor
        logic       prev;
        logic [7:0] got;
        logic [7:0] e;
        logic       fv, mv, sbit, pbit, pbusy;
        bit         aborted, cells_ok;
        int         exp_cnt;
        prev    = 1'b1;
        exp_cnt = 0;
        fv = 1'b1; mv = 1'b1; sbit = 1'b1; pbit = 1'b0; pbusy = 1'b0;
        forever begin
            @(negedge clk_50M);
            if (rst) begin
                exp_cnt = 0;
                prev    = 1'b1;
            end else if (prev && !bus.tx) begin
                launch_cyc.push_back(cyc);
                exp_cnt = (exp_cnt + 1) % 256;
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_frame: launch at cycle %0d with empty queue", cyc);
                    e = 8'h00;
                end else begin
                    e = exp_q.pop_front();
                end
                check("last_frame", bus.last_frame, e);
                check("frame_cnt", bus.frame_cnt, exp_cnt);
                check("busy_in_frame", bus.busy, 1);
                aborted  = 0;
                cells_ok = 1;
                got      = '0;
                for (int k = 0; k < 10 && !aborted; k++) begin
                    for (int j = 0; j < C && !aborted; j++) begin
                        if (k != 0 || j != 0) begin
                            @(negedge clk_50M);
                            if (rst) aborted = 1;
                        end
                        if (!aborted) begin
                            if (j == 0) fv = bus.tx;
                            if (j == C / 2) mv = bus.tx;
                            if (j == C - 1) begin
                                if (fv != mv || mv != bus.tx) cells_ok = 0;
                                if (k == 0) sbit = mv;
                                else if (k == 9) begin
                                    pbit  = mv;
                                    pbusy = bus.busy;
                                end else got[k-1] = mv;
                            end
                        end
                    end
                end
                if (aborted) begin
                    exp_cnt = 0;
                end else begin
                    check("start_bit", sbit, 0);
                    check("stop_bit", pbit, 1);
                    check("busy_through_stop", pbusy, 1);
                    check("bit_cells", cells_ok, 1);
                    check("byte", got, e);
                    frames_done++;
                end
                prev = bus.tx;
            end else begin
                prev = bus.tx;
            end
        end
    end

    initial begin : stimulus
        logic [1:0] m, fn;
        logic       f, b, l, r, a;
        logic [5:0] sp;
        bit         pushed;
        int         snap;
        int         n;

        bus.mode_sel = 2'b11; bus.fwd = 0; bus.back = 0; bus.left = 0; bus.right = 0;
        bus.avoid = 0; bus.speed_set = '0; bus.func_sel = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk_50M);
        @(negedge clk_50M);
        check("rst_tx", bus.tx, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_last_frame", bus.last_frame, 0);
        check("rst_frame_cnt", bus.frame_cnt, 0);

        // Reset always produces a frame of whatever is currently composed.
        model_last = cur_model();
        exp_q.push_back(model_last);
        @(posedge clk_50M); #1 rst = 1'b0;
        @(posedge clk_50M); @(negedge clk_50M);
        check("launch_after_release", bus.tx, 0);
        wait_frames(1, "reset_c0");

        step(2'd0, 1, 0, 1, 0, 0, 6'd0, 2'd0, "fwd_left");
        step(2'd0, 1, 1, 1, 1, 0, 6'd0, 2'd0, "conflict");
        step(2'd2, 0, 0, 0, 0, 0, 6'd0, 2'd2, "park");
        step(2'd0, 0, 1, 0, 1, 1, 6'd0, 2'd0, "avoid_back_right");

        for (int i = 0; i < 24; i++) begin
            n = 0;
            do begin
                m  = 2'($urandom_range(0, 3));
                f  = 1'($urandom); b = 1'($urandom); l = 1'($urandom);
                r  = 1'($urandom); a = 1'($urandom);
                sp = 6'($urandom); fn = 2'($urandom);
                n++;
            end while (model(m, f, b, l, r, a, sp, fn) == model_last && n < 16);
            step(m, f, b, l, r, a, sp, fn, "random");
        end

        // Mid-frame changes coalesce into one follow-up frame carrying the newest value.
        step(2'd2, 0, 0, 0, 0, 0, 6'd0, 2'd3, "pre_speed");
        set_inputs(2'd1, 0, 0, 0, 0, 0, 6'd20, 2'd3);
        expect_current(pushed);
        wait_busy("speed20");
        repeat (3 * C) @(posedge clk_50M);
        set_inputs(2'd1, 0, 0, 0, 0, 0, 6'd25, 2'd3);
        repeat (2 * C) @(posedge clk_50M);
        set_inputs(2'd1, 0, 0, 0, 0, 0, 6'd30, 2'd3);
        expect_current(pushed);
        wait_frames(2, "coalesce");
        snap = frames_done;
        repeat (40) @(negedge clk_50M);
        check("no_extra_frame", frames_done, snap);

        // Static controls: keep-alive resends the same byte every frame + refresh period.
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(model_last);
            wait_frames(1, "refresh");
            check("refresh_period", launch_cyc[$] - launch_cyc[$-1], FRAME + R);
        end

        // Reset part-way through a frame aborts it; a fresh frame follows release.
        set_inputs(2'd0, 1, 0, 0, 0, 0, 6'd0, 2'd0);
        expect_current(pushed);
        wait_busy("pre_abort");
        repeat (4 * C + 3) @(posedge clk_50M);
        #1 rst = 1'b1;
        @(posedge clk_50M); @(negedge clk_50M);
        check("abort_tx", bus.tx, 1);
        check("abort_busy", bus.busy, 0);
        check("abort_frame_cnt", bus.frame_cnt, 0);
        model_last = cur_model();
        exp_q.push_back(model_last);
        @(posedge clk_50M); #1 rst = 1'b0;
        @(posedge clk_50M); @(negedge clk_50M);
        check("launch_after_abort", bus.tx, 0);
        wait_frames(1, "after_abort");

        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
